reg_scoreboard: RTL and testbench

//  Issue-side hazard unit paired with the EX/MEM forwarding network: tracks registers with

---
 rtl/riscv_pkg.sv | 14 +
 rtl/sb_busy_file.sv | 59 +++++
 rtl/reg_scoreboard.sv | 93 +++++++++
 tb/tb_reg_scoreboard.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared register-file definitions used by the issue-side hazard logic.
package riscv_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // x0 is hardwired zero, so it never carries a dependency.
    function automatic logic reg_nz(input reg_addr_t r);
        return r != '0;
    endfunction

endpackage

// File: rtl/sb_busy_file.sv
// Busy bit per architectural register plus a count of pending long-latency writes.
// A set and a clear on the same register in one cycle leaves the register busy.
module sb_busy_file
    import riscv_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    output logic [NUM_REGS-1:0]   busy_vec,
    output logic [CNT_W-1:0]      outstanding
);

    logic [NUM_REGS-1:0] busy_reg;
    logic [NUM_REGS-1:0] busy_next;
    logic [CNT_W-1:0]    cnt_reg;
    logic [CNT_W-1:0]    cnt_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_bit
            if (gi == 0) begin : g_zero
                assign busy_next[gi] = 1'b0;
            end else begin : g_reg
                assign busy_next[gi] = (set_en && set_addr == reg_addr_t'(gi)) ||
                                       (busy_reg[gi] && !(clr_en && clr_addr == reg_addr_t'(gi)));
            end
        end
    endgenerate

    // Simultaneous set and clear cancel out whether or not they hit the same register.
    always_comb begin
        cnt_next = cnt_reg;
        if (set_en && !clr_en && cnt_reg != CNT_W'(MAX_OUTSTANDING)) begin
            cnt_next = cnt_reg + 1'b1;
        end else if (clr_en && !set_en && cnt_reg != '0) begin
            cnt_next = cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            busy_reg <= busy_next;
            cnt_reg  <= cnt_next;
        end
    end

    assign busy_vec    = busy_reg;
    assign outstanding = cnt_reg;

endmodule

// File: rtl/reg_scoreboard.sv
// Issue-side hazard unit: tracks pending variable-latency writes, detects load-use,
// and selects writeback bypass for ID operands. Stall is combinational.
module reg_scoreboard
    import riscv_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_long_lat,
    input  logic                  idex_mem_read,
    input  logic [REG_ADDR_W-1:0] idex_rd,
    input  logic                  flush,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  stall,
    output logic                  issue,
    output logic                  fwd_wb_rs1,
    output logic                  fwd_wb_rs2,
    output logic [NUM_REGS-1:0]   busy_vec,
    output logic [CNT_W-1:0]      outstanding,
    output logic                  sb_error
);

    logic wb_hit;
    logic wb_err;
    logic hit_rs1, hit_rs2, hit_rd;
    logic haz_rs1, haz_rs2, haz_waw, haz_load_use, haz_full;
    logic set_en;
    logic sb_error_reg;

    // A writeback only counts as a hit when it retires a genuinely pending register.
    assign wb_hit  = wb_valid && reg_nz(wb_rd) && busy_vec[wb_rd];
    assign wb_err  = wb_valid && (!reg_nz(wb_rd) || !busy_vec[wb_rd]);

    assign hit_rs1 = wb_hit && (wb_rd == id_rs1);
    assign hit_rs2 = wb_hit && (wb_rd == id_rs2);
    assign hit_rd  = wb_hit && (wb_rd == id_rd);

    assign haz_rs1 = id_rs1_used && reg_nz(id_rs1) && busy_vec[id_rs1] && !hit_rs1;
    assign haz_rs2 = id_rs2_used && reg_nz(id_rs2) && busy_vec[id_rs2] && !hit_rs2;
    assign haz_waw = id_reg_write && reg_nz(id_rd) && busy_vec[id_rd] && !hit_rd;

    assign haz_load_use = idex_mem_read && reg_nz(idex_rd) &&
                          ((id_rs1_used && idex_rd == id_rs1) ||
                           (id_rs2_used && idex_rd == id_rs2));

    assign haz_full = id_long_lat && id_reg_write && reg_nz(id_rd) &&
                      (outstanding == CNT_W'(MAX_OUTSTANDING));

    // Flush wins over every hazard: the squashed instruction must not hold the front end.
    assign stall = id_valid && !flush &&
                   (haz_rs1 || haz_rs2 || haz_waw || haz_load_use || haz_full);
    assign issue = id_valid && !stall && !flush;

    assign fwd_wb_rs1 = id_rs1_used && reg_nz(id_rs1) && hit_rs1;
    assign fwd_wb_rs2 = id_rs2_used && reg_nz(id_rs2) && hit_rs2;

    assign set_en = issue && id_long_lat && id_reg_write && reg_nz(id_rd);

    sb_busy_file #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_busy_file (
        .clk         (clk),
        .rst         (rst),
        .set_en      (set_en),
        .set_addr    (id_rd),
        .clr_en      (wb_hit),
        .clr_addr    (wb_rd),
        .busy_vec    (busy_vec),
        .outstanding (outstanding)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_error_reg <= 1'b0;
        end else if (wb_err) begin
            sb_error_reg <= 1'b1;
        end
    end

    assign sb_error = sb_error_reg;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: load-use vector table, directed
// multi-cycle sequences and randomized traffic against a set-of-busy-registers model.
module tb_reg_scoreboard;

    localparam int MAX_OUT = 4;

    logic        clk;
    logic        rst;
    logic        id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_long_lat;
    logic [4:0]  id_rs1, id_rs2, id_rd, idex_rd, wb_rd;
    logic        idex_mem_read, flush, wb_valid;
    logic        stall, issue, fwd_wb_rs1, fwd_wb_rs2, sb_error;
    logic [31:0] busy_vec;
    logic [2:0]  outstanding;

    reg_scoreboard dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rs1_used   (id_rs1_used),
        .id_rs2_used   (id_rs2_used),
        .id_rd         (id_rd),
        .id_reg_write  (id_reg_write),
        .id_long_lat   (id_long_lat),
        .idex_mem_read (idex_mem_read),
        .idex_rd       (idex_rd),
        .flush         (flush),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .stall         (stall),
        .issue         (issue),
        .fwd_wb_rs1    (fwd_wb_rs1),
        .fwd_wb_rs2    (fwd_wb_rs2),
        .busy_vec      (busy_vec),
        .outstanding   (outstanding),
        .sb_error      (sb_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       id_valid;
        logic [4:0] id_rs1;
        logic       id_rs1_used;
        logic [4:0] id_rs2;
        logic       id_rs2_used;
        logic [4:0] id_rd;
        logic       id_reg_write;
        logic       id_long_lat;
        logic       idex_mem_read;
        logic [4:0] idex_rd;
        logic       flush;
        logic       wb_valid;
        logic [4:0] wb_rd;
    } in_t;

    typedef struct packed {
        logic       valid;
        logic       fl;
        logic       mr;
        logic [4:0] xrd;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic       exp_stall;
        logic       exp_issue;
    } lu_vec_t;

    int tests = 0;
    int fails = 0;

    // Model state: the set of registers awaiting a long-latency result, and the error flag.
    logic [31:0] busy_m;
    logic        err_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic in_t idle();
        in_t v;
        v = '0;
        return v;
    endfunction

    function automatic logic m_wbhit(input in_t v, input logic [4:0] r);
        return v.wb_valid && v.wb_rd == r && r != 5'd0 && busy_m[r];
    endfunction

    function automatic logic m_stall(input in_t v);
        logic src1, src2, waw, lu, full;
        src1 = v.id_rs1_used && v.id_rs1 != 5'd0 && busy_m[v.id_rs1] && !m_wbhit(v, v.id_rs1);
        src2 = v.id_rs2_used && v.id_rs2 != 5'd0 && busy_m[v.id_rs2] && !m_wbhit(v, v.id_rs2);
        waw  = v.id_reg_write && v.id_rd != 5'd0 && busy_m[v.id_rd] && !m_wbhit(v, v.id_rd);
        lu   = v.idex_mem_read && v.idex_rd != 5'd0 &&
               ((v.id_rs1_used && v.idex_rd == v.id_rs1) || (v.id_rs2_used && v.idex_rd == v.id_rs2));
        full = v.id_long_lat && v.id_reg_write && v.id_rd != 5'd0 && $countones(busy_m) == MAX_OUT;
        return v.id_valid && !v.flush && (src1 || src2 || waw || lu || full);
    endfunction

    function automatic logic m_issue(input in_t v);
        return v.id_valid && !v.flush && !m_stall(v);
    endfunction

    task automatic m_update(input in_t v);
        logic [31:0] old_busy;
        logic        iss;
        old_busy = busy_m;
        iss      = m_issue(v);
        if (v.wb_valid && (v.wb_rd == 5'd0 || !old_busy[v.wb_rd])) err_m = 1'b1;
        if (m_wbhit(v, v.wb_rd)) busy_m[v.wb_rd] = 1'b0;
        if (iss && v.id_long_lat && v.id_reg_write && v.id_rd != 5'd0) busy_m[v.id_rd] = 1'b1;
    endtask

    task automatic drive(input in_t v);
        id_valid      = v.id_valid;
        id_rs1        = v.id_rs1;
        id_rs1_used   = v.id_rs1_used;
        id_rs2        = v.id_rs2;
        id_rs2_used   = v.id_rs2_used;
        id_rd         = v.id_rd;
        id_reg_write  = v.id_reg_write;
        id_long_lat   = v.id_long_lat;
        idex_mem_read = v.idex_mem_read;
        idex_rd       = v.idex_rd;
        flush         = v.flush;
        wb_valid      = v.wb_valid;
        wb_rd         = v.wb_rd;
    endtask

    // Called at posedge+1: drive, let the combinational outputs settle, compare them.
    task automatic settle(input in_t v);
        drive(v);
        #2;
        check("stall", 32'(stall), 32'(m_stall(v)));
        check("issue", 32'(issue), 32'(m_issue(v)));
        check("fwd_wb_rs1", 32'(fwd_wb_rs1),
              32'(v.id_rs1_used && v.id_rs1 != 5'd0 && m_wbhit(v, v.id_rs1)));
        check("fwd_wb_rs2", 32'(fwd_wb_rs2),
              32'(v.id_rs2_used && v.id_rs2 != 5'd0 && m_wbhit(v, v.id_rs2)));
    endtask

    // Advance one clock, update the model, and compare the registered state.
    task automatic tick(input in_t v);
        @(posedge clk);
        m_update(v);
        #1;
        check("busy_vec", busy_vec, busy_m);
        check("outstanding", 32'(outstanding), 32'($countones(busy_m)));
        check("sb_error", 32'(sb_error), 32'(err_m));
    endtask

    task automatic cycle(input in_t v);
        settle(v);
        tick(v);
    endtask

    function automatic in_t long_op(input logic [4:0] rd);
        in_t v;
        v = idle();
        v.id_valid     = 1'b1;
        v.id_rd        = rd;
        v.id_reg_write = 1'b1;
        v.id_long_lat  = 1'b1;
        return v;
    endfunction

    function automatic in_t wb_only(input logic [4:0] rd);
        in_t v;
        v = idle();
        v.wb_valid = 1'b1;
        v.wb_rd    = rd;
        return v;
    endfunction

    task automatic sync_reset();
        rst = 1'b1;
        busy_m = '0;
        err_m  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    lu_vec_t tbl[8];

    initial begin
        in_t v;
        in_t add_op;
        logic [4:0] r;

        tbl[0] = '{1'b1, 1'b0, 1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 5'd7, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 5'd7, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 5'd9, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1};

        busy_m = '0;
        err_m  = 1'b0;
        drive(idle());
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset busy_vec", busy_vec, 32'd0);
        check("reset outstanding", 32'(outstanding), 32'd0);
        check("reset sb_error", 32'(sb_error), 32'd0);

        // Load-use and flush vectors with an empty scoreboard
        for (int i = 0; i < 8; i++) begin
            v = idle();
            v.id_valid      = tbl[i].valid;
            v.flush         = tbl[i].fl;
            v.idex_mem_read = tbl[i].mr;
            v.idex_rd       = tbl[i].xrd;
            v.id_rs1        = tbl[i].rs1;
            v.id_rs1_used   = tbl[i].u1;
            v.id_rs2        = tbl[i].rs2;
            v.id_rs2_used   = tbl[i].u2;
            settle(v);
            check($sformatf("tbl%0d stall", i), 32'(stall), 32'(tbl[i].exp_stall));
            check($sformatf("tbl%0d issue", i), 32'(issue), 32'(tbl[i].exp_issue));
            tick(v);
        end

        // Flushed long op must not mark its destination busy
        v = long_op(5'd12);
        v.flush = 1'b1;
        cycle(v);
        check("flush no busy", 32'(busy_vec[12]), 32'd0);

        // Long write to x5, then add x6,x5,x1 stalls until x5 retires
        cycle(long_op(5'd5));
        check("t1 busy5", 32'(busy_vec[5]), 32'd1);
        add_op = idle();
        add_op.id_valid     = 1'b1;
        add_op.id_rs1       = 5'd5;
        add_op.id_rs1_used  = 1'b1;
        add_op.id_rs2       = 5'd1;
        add_op.id_rs2_used  = 1'b1;
        add_op.id_rd        = 5'd6;
        add_op.id_reg_write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle(add_op);
            check("t1 stall", 32'(stall), 32'd1);
            tick(add_op);
            check("t1 outstanding", 32'(outstanding), 32'd1);
        end
        v = add_op;
        v.wb_valid = 1'b1;
        v.wb_rd    = 5'd5;
        settle(v);
        check("t2 stall", 32'(stall), 32'd0);
        check("t2 fwd_wb_rs1", 32'(fwd_wb_rs1), 32'd1);
        check("t2 issue", 32'(issue), 32'd1);
        tick(v);
        check("t2 busy5", 32'(busy_vec[5]), 32'd0);
        check("t2 outstanding", 32'(outstanding), 32'd0);

        // Load-use stalls exactly one cycle: the bubble clears the EX load
        v = idle();
        v.id_valid = 1'b1;
        v.id_rs2 = 5'd7;
        v.id_rs2_used = 1'b1;
        v.idex_mem_read = 1'b1;
        v.idex_rd = 5'd7;
        settle(v);
        check("t3 stall", 32'(stall), 32'd1);
        tick(v);
        v.idex_mem_read = 1'b0;
        v.idex_rd = 5'd0;
        settle(v);
        check("t3 stall after bubble", 32'(stall), 32'd0);
        tick(v);

        // Fill to capacity, fifth long op waits for a retirement
        for (int i = 1; i <= 4; i++) cycle(long_op(5'(i)));
        check("t4 outstanding full", 32'(outstanding), 32'd4);
        for (int i = 0; i < 2; i++) begin
            settle(long_op(5'd8));
            check("t4 stall full", 32'(stall), 32'd1);
            tick(long_op(5'd8));
        end
        v = long_op(5'd8);
        v.wb_valid = 1'b1;
        v.wb_rd    = 5'd2;
        settle(v);
        check("t4 stall on wb cycle", 32'(stall), 32'd1);
        tick(v);
        settle(long_op(5'd8));
        check("t4 fifth issues", 32'(issue), 32'd1);
        tick(long_op(5'd8));
        check("t4 outstanding", 32'(outstanding), 32'd4);
        check("t4 busy8", 32'(busy_vec[8]), 32'd1);
        cycle(wb_only(5'd1));
        cycle(wb_only(5'd3));
        cycle(wb_only(5'd4));
        cycle(wb_only(5'd8));
        check("t4 drained", 32'(outstanding), 32'd0);

        // Same-cycle set and clear on x9
        cycle(long_op(5'd9));
        v = long_op(5'd9);
        v.wb_valid = 1'b1;
        v.wb_rd    = 5'd9;
        settle(v);
        check("t5 stall", 32'(stall), 32'd0);
        tick(v);
        check("t5 busy9", 32'(busy_vec[9]), 32'd1);
        check("t5 outstanding", 32'(outstanding), 32'd1);
        cycle(wb_only(5'd9));

        // Writeback to an idle register is a sticky error
        cycle(wb_only(5'd3));
        check("t6 sb_error", 32'(sb_error), 32'd1);
        check("t6 busy untouched", busy_vec, 32'd0);
        cycle(idle());
        check("t6 sb_error sticky", 32'(sb_error), 32'd1);
        cycle(wb_only(5'd0));
        for (int i = 10; i <= 12; i++) cycle(long_op(5'(i)));
        check("t6 outstanding 3", 32'(outstanding), 32'd3);

        // Asynchronous reset mid-cycle with a dependent instruction in ID
        v = idle();
        v.id_valid    = 1'b1;
        v.id_rs1      = 5'd10;
        v.id_rs1_used = 1'b1;
        drive(v);
        #2;
        check("t6 stall before rst", 32'(stall), 32'd1);
        rst = 1'b1;
        #1;
        check("t6 rst busy_vec", busy_vec, 32'd0);
        check("t6 rst outstanding", 32'(outstanding), 32'd0);
        check("t6 rst sb_error", 32'(sb_error), 32'd0);
        check("t6 rst stall", 32'(stall), 32'd0);
        busy_m = '0;
        err_m  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            if (n == 750) sync_reset();
            v = idle();
            v.id_valid      = ($urandom_range(0, 9) < 8);
            v.id_rs1        = 5'($urandom_range(0, 7));
            v.id_rs1_used   = 1'($urandom_range(0, 1));
            v.id_rs2        = 5'($urandom_range(0, 7));
            v.id_rs2_used   = 1'($urandom_range(0, 1));
            v.id_rd         = 5'($urandom_range(0, 7));
            v.id_reg_write  = ($urandom_range(0, 3) != 0);
            v.id_long_lat   = ($urandom_range(0, 4) < 2);
            v.idex_mem_read = ($urandom_range(0, 9) < 3);
            v.idex_rd       = 5'($urandom_range(0, 7));
            v.flush         = ($urandom_range(0, 9) == 0);
            v.wb_valid      = ($urandom_range(0, 9) < 3);
            if (busy_m != 32'd0 && $urandom_range(0, 19) != 0) begin
                do r = 5'($urandom_range(1, 7)); while (!busy_m[r]);
                v.wb_rd = r;
            end else begin
                v.wb_rd = 5'($urandom_range(0, 7));
            end
            cycle(v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
